verserial_fifo: RTL
===================

Name: verserial_fifo

Overview:
- Next-generation memory-mapped UART for the Verbus peripheral space.
- Data width is parametrised; parity and stop-bit count are runtime-selectable.
- Adds TX and RX FIFOs, a 2-flop RX synchroniser and error detection (parity, framing, overrun, TX overflow).
- Sits on the bus as a read/write responder and drives one interrupt line to the CPU.

Parameters:
- DATA_BITS, 8, character width, legal 5..8
- TX_DEPTH, 8, TX FIFO entries, power of two, at least 2
- RX_DEPTH, 8, RX FIFO entries, power of two, at least 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- valid  in  1  bus request valid
- address  in  32  byte address; local register index = address[4:2]
- wstrobe  in  4  byte write enables; all zero means read
- wdata  in  32  write data
- rdata  out  32  read data, combinational from address
- ready  out  1  tied to 1
- irq  out  1  interrupt request
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output; idle high

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Register map, index = address[4:2]:
  - 0 CONTROL: b0 tx_irq_en, b1 rx_irq_en, b2 err_irq_en, b3 parity_en, b4 parity_odd, b5 two_stop.
  - 1 STATUS: b0 tx_event, b1 rx_event, b2 rx_overrun, b3 framing_err, b4 parity_err, b5 tx_overflow. These are W1C, byte-masked by wstrobe.
  - 2 DIVISION: 32 bits.
  - 3 DATA: write pushes wdata[DATA_BITS-1:0] to the TX FIFO; read returns the RX head zero-extended and pops it.
  - 4 LEVEL, read-only: [15:0] TX fill, [31:16] RX fill.
  - 5..7: read 0, writes ignored.
- Write to CONTROL or DIVISION: byte-masked by wstrobe; lanes without a strobe are kept.
- Read (valid, wstrobe==0) at DATA with RX empty: rdata=0, no state change.
- DATA push happens when valid, index 3 and wstrobe[0] are all set. Push while TX full: data dropped and tx_overflow set.
- Reset values:
  - CONTROL, STATUS, DIVISION = 0.
  - Both FIFOs empty.
  - tx=1, irq=0.
  - Both engines IDLE; synchroniser flops = 1.
- Bit period = DIVISION+1 cycles.
- Frame format: start(0), DATA_BITS LSB-first, parity if parity_en, then 1 stop bit (2 if two_stop).
  - Even parity: bit = XOR of data. Odd parity: bit = inverted XOR of data.
- CONTROL changes take effect at the next frame start; a frame in flight keeps its settings.
- TX FSM, IDLE → SHIFT:
  - IDLE with TX FIFO non-empty: pop the head, drive tx=0 on the next cycle, enter SHIFT.
  - SHIFT: each bit is held DIVISION+1 cycles.
  - After the last stop bit: if the FIFO is non-empty, start the next frame with no idle gap. Otherwise go to IDLE and pulse done, which sets tx_event.
- RX synchronisation: rx passes through 2 flops (rxs), adding 2 cycles of latency.
- RX FSM, IDLE → START → DATA → PARITY → STOP → WAIT_HIGH:
  - IDLE: rxs=0 enters START; counter loaded with DIVISION.
  - Each bit is sampled when the counter equals DIVISION/2 (integer divide). The counter reloads at 0.
  - START sample = 1: false start, return to IDLE, no flags.
  - PARITY mismatch: parity_err set.
  - STOP sample = 0: framing_err set, character discarded, enter WAIT_HIGH. WAIT_HIGH returns to IDLE when rxs=1.
  - Only the first stop bit is checked.
  - Good stop and no parity error: push to the RX FIFO and set rx_event. If the RX FIFO is full, the character is dropped and rx_overrun set.
  - A character with a parity error is discarded.
  - After STOP, go to IDLE immediately when rxs=1.
- Flag priority: a hardware set and a W1C clear in the same cycle → set wins.
- FIFOs:
  - Simultaneous push and pop on the same FIFO is legal; fill is unchanged.
  - A simultaneous push and pop on a full FIFO succeeds.
  - Read/write pointers wrap modulo depth; fill counters are $clog2(DEPTH)+1 bits wide.
- irq = (tx_irq_en & tx_event) | (rx_irq_en & rx_event) | (err_irq_en & any of b2..b5). Combinational from registers.
- Reset mid-frame: tx returns to 1 on the next cycle, the partial RX character is lost, and FIFOs are emptied.
- DIVISION=0: 1 cycle/bit, sample at count 0. Legal for TX; RX is not guaranteed.

Test Plan:
- TX basic, 8N1: DIVISION=3, write DATA=0xA5. tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1. tx_event sets 1 cycle after the stop bit ends; LEVEL[15:0] goes 1→0 at frame start.
- TX FIFO burst: DIVISION=1, write 9 bytes with TX_DEPTH=8 while the first frame starts. Expected: 9 back-to-back frames with no idle gap; tx_overflow=0. A 10th write while full sets tx_overflow, and irq=1 if err_irq_en is set.
- RX loopback with parity: tx tied to rx, CONTROL=parity_en|parity_odd|rx_irq_en, send 0x3C. Expected: RX fill=1, irq=1, DATA read=0x3C, fill=0; W1C STATUS=0x2 clears irq.
- RX errors: drive a frame with a bad parity bit → parity_err=1, fill unchanged. Drive a frame with stop=0 → framing_err=1, and no new start is detected until rx returns high.
- Overrun: with RX_DEPTH=8, receive 9 characters with no reads. Expected: fill=8, rx_overrun=1; reads return the first 8 in order.
- Simultaneous clear/set and reset: issue a STATUS W1C of rx_event in the same cycle as a push → rx_event stays 1. Assert reset mid-frame → tx=1 next cycle, LEVEL=0.

Source files
------------

// File: rtl/verserial_fifo.sv
// verserial_fifo: memory-mapped UART responder with TX/RX FIFOs.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   valid, address,     - bus request; register index = address[4:2]
//   wstrobe, wdata        (wstrobe all zero means read)
//   rdata, ready        - combinational read data; ready is always 1
//   irq                 - interrupt, combinational from CONTROL/STATUS
//   rx, tx              - serial input (asynchronous) and output (idle high)
// Registers: 0 CONTROL, 1 STATUS (W1C), 2 DIVISION, 3 DATA, 4 LEVEL.
// Bus handshake: a request is taken in every cycle that valid is high;
// ready is tied high, so there is never a stall.
module verserial_fifo #(
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq,
  input  logic        rx,
  output logic        tx
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int FW  = DATA_BITS + 4;
  localparam logic [TAW:0] TX_FULL = TX_DEPTH[TAW:0];
  localparam logic [RAW:0] RX_FULL = RX_DEPTH[RAW:0];

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // Registers
  logic [5:0]  ctrl_q, ctrl_d, status_q, status_d;
  logic [31:0] div_q, div_d;
  // FIFOs
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  // TX engine
  tx_state_e   tx_state_q, tx_state_d;
  logic [FW-1:0] tx_frame_q, tx_frame_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic [31:0] tx_baud_q, tx_baud_d;
  logic        tx_done_q, tx_done_d;
  // RX engine
  logic        rx_s1_q, rx_s2_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] rx_baud_q, rx_baud_d;
  logic [2:0]  rx_bitn_q, rx_bitn_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic        rx_pe_q, rx_pe_d, rx_odd_q, rx_odd_d, rx_bad_q, rx_bad_d;

  logic [2:0]  idx;
  logic        wr_en, rd_en, tx_push, tx_push_ok, tx_pop, tx_load;
  logic        rx_push, rx_push_ok, rx_pop, rx_sample, rxs;
  logic        perr_set, ferr_set;
  logic [DATA_BITS-1:0] tx_head;
  logic        tx_par;
  logic        unused_addr;

  assign idx         = address[4:2];
  assign wr_en       = valid && (wstrobe != 4'h0);
  assign rd_en       = valid && (wstrobe == 4'h0);
  assign ready       = 1'b1;
  assign unused_addr = ^{address[31:5], address[1:0]};

  assign tx_push    = wr_en && (idx == 3'd3) && wstrobe[0];
  // A push into a full FIFO still lands when the same cycle pops.
  assign tx_push_ok = tx_push && ((tx_cnt_q != TX_FULL) || tx_pop);
  assign rx_pop     = rd_en && (idx == 3'd3) && (rx_cnt_q != '0);
  assign rx_push_ok = rx_push && ((rx_cnt_q != RX_FULL) || rx_pop);

  assign tx_head = tx_mem[tx_rptr_q];
  assign tx_par  = ctrl_q[4] ? ~^tx_head : ^tx_head;
  assign tx      = (tx_state_q == TX_SHIFT) ? tx_frame_q[0] : 1'b1;
  assign rxs     = rx_s2_q;
  assign rx_sample = (rx_baud_q == {1'b0, div_q[31:1]});

  assign irq = (ctrl_q[0] & status_q[0]) | (ctrl_q[1] & status_q[1]) |
               (ctrl_q[2] & (|status_q[5:2]));

  // TX engine: the frame register shifts right, refilling with 1s so the
  // stop bits fall out naturally; tx_bits counts bits left in the frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_frame_d = tx_frame_q;
    tx_bits_d  = tx_bits_q;
    tx_baud_d  = tx_baud_q;
    tx_done_d  = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (tx_cnt_q != '0) tx_load = 1'b1;
      TX_SHIFT: begin
        if (tx_baud_q == 32'd0) begin
          tx_baud_d  = div_q;
          tx_frame_d = {1'b1, tx_frame_q[FW-1:1]};
          tx_bits_d  = tx_bits_q - 4'd1;
          if (tx_bits_q == 4'd1) begin
            if (tx_cnt_q != '0) tx_load = 1'b1;
            else begin
              tx_state_d = TX_IDLE;
              tx_done_d  = 1'b1;
            end
          end
        end else begin
          tx_baud_d = tx_baud_q - 32'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_pop = tx_load;
    if (tx_load) begin
      tx_state_d = TX_SHIFT;
      tx_baud_d  = div_q;
      tx_frame_d = ctrl_q[3] ? {2'b11, tx_par, tx_head, 1'b0}
                             : {3'b111, tx_head, 1'b0};
      tx_bits_d  = 4'(DATA_BITS + 2) + {3'b000, ctrl_q[3]} + {3'b000, ctrl_q[5]};
    end
  end

  // RX engine: baud counter runs from DIVISION down to 0 and samples at
  // DIVISION/2. Parity settings are latched when the start edge is seen.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bitn_d  = rx_bitn_q;
    rx_shift_d = rx_shift_q;
    rx_pe_d    = rx_pe_q;
    rx_odd_d   = rx_odd_q;
    rx_bad_d   = rx_bad_q;
    rx_push    = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    if (rx_state_q != RX_IDLE)
      rx_baud_d = (rx_baud_q == 32'd0) ? div_q : rx_baud_q - 32'd1;
    case (rx_state_q)
      RX_IDLE: if (!rxs) begin
        rx_state_d = RX_START;
        rx_baud_d  = div_q;
        rx_pe_d    = ctrl_q[3];
        rx_odd_d   = ctrl_q[4];
        rx_bad_d   = 1'b0;
      end
      RX_START: if (rx_sample) begin
        if (rxs) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA;
          rx_bitn_d  = 3'd0;
        end
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rxs, rx_shift_q[DATA_BITS-1:1]};
        rx_bitn_d  = rx_bitn_q + 3'd1;
        if (rx_bitn_q == 3'(DATA_BITS - 1))
          rx_state_d = rx_pe_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_sample) begin
        if (rxs != (rx_odd_q ? ~^rx_shift_q : ^rx_shift_q)) begin
          perr_set = 1'b1;
          rx_bad_d = 1'b1;
        end
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        if (!rxs) begin
          ferr_set   = 1'b1;
          rx_state_d = RX_WAIT_HIGH;
        end else begin
          rx_state_d = RX_IDLE;
          rx_push    = !rx_bad_q;
        end
      end
      RX_WAIT_HIGH: if (rxs) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Registers, FIFO pointers and status flags; hardware sets beat W1C.
  always_comb begin
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    status_d = status_q;
    if (wr_en && (idx == 3'd0) && wstrobe[0]) ctrl_d = wdata[5:0];
    for (int b = 0; b < 4; b++)
      if (wr_en && (idx == 3'd2) && wstrobe[b]) div_d[8*b +: 8] = wdata[8*b +: 8];
    if (wr_en && (idx == 3'd1) && wstrobe[0]) status_d = status_q & ~wdata[5:0];
    status_d = status_d | {tx_push && !tx_push_ok, perr_set, ferr_set,
                           rx_push && !rx_push_ok, rx_push_ok, tx_done_q};

    tx_wptr_d = tx_push_ok ? tx_wptr_q + TAW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop     ? tx_rptr_q + TAW'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push_ok && !tx_pop) tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
    if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - (TAW+1)'(1);

    rx_wptr_d = rx_push_ok ? rx_wptr_q + RAW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop     ? rx_rptr_q + RAW'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push_ok && !rx_pop) rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
    if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      3'd0: rdata = {26'd0, ctrl_q};
      3'd1: rdata = {26'd0, status_q};
      3'd2: rdata = div_q;
      3'd3: if (rx_cnt_q != '0) rdata = 32'(rx_mem[rx_rptr_q]);
      3'd4: rdata = {16'(rx_cnt_q), 16'(tx_cnt_q)};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr_q] <= wdata[DATA_BITS-1:0];
    if (rx_push_ok) rx_mem[rx_wptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      div_q      <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_frame_q <= '1;
      tx_bits_q  <= '0;
      tx_baud_q  <= '0;
      tx_done_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bitn_q  <= '0;
      rx_shift_q <= '0;
      rx_pe_q    <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_bad_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      div_q      <= div_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_frame_q <= tx_frame_d;
      tx_bits_q  <= tx_bits_d;
      tx_baud_q  <= tx_baud_d;
      tx_done_q  <= tx_done_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bitn_q  <= rx_bitn_d;
      rx_shift_q <= rx_shift_d;
      rx_pe_q    <= rx_pe_d;
      rx_odd_q   <= rx_odd_d;
      rx_bad_q   <= rx_bad_d;
    end
  end
endmodule
